// File: rtl/branch_sequencer.sv
// branch_sequencer: owns the PC register and PCMUX, and runs the BR
// micro-sequence (IDLE -> WAIT -> EVAL -> DONE) when started by the ISDU.
// All outputs are registered; none depend combinationally on inputs.
module branch_sequencer #(
    parameter int              WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_pc,
    input  logic [1:0]       pcmux_sel,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [WIDTH-1:0] ir,
    input  logic             br_start,
    input  logic             ben,
    output logic [WIDTH-1:0] pc,
    output logic             br_busy,
    output logic             br_done,
    output logic             br_taken
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] off;
    logic [WIDTH-1:0] sext_ir;
    logic [WIDTH-1:0] pc_normal;
    logic             unused_ir_hi;

    // Only IR[8:0] feeds the offset; the upper opcode/condition bits are not used here.
    assign unused_ir_hi = ^ir[WIDTH-1:9];

    // PCMUX for the normal (non-branch) PC path, including the SEXT of IR[8:0].
    always_comb begin
        sext_ir   = {{(WIDTH-9){ir[8]}}, ir[8:0]};
        pc_normal = pc;
        if (ld_pc) begin
            case (pcmux_sel)
                2'b00:   pc_normal = pc + WIDTH'(1);
                2'b01:   pc_normal = bus_in;
                2'b10:   pc_normal = pc + sext_ir;
                default: pc_normal = pc;
            endcase
        end
    end

    // BR sequencer FSM with registered busy/done/taken decodes and PC update.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            state    <= IDLE;
            off      <= '0;
            br_busy  <= 1'b0;
            br_done  <= 1'b0;
            br_taken <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    br_done <= 1'b0;
                    if (br_start) begin
                        off     <= sext_ir;
                        state   <= WAIT;
                        br_busy <= 1'b1;
                    end else begin
                        pc <= pc_normal;
                    end
                end
                WAIT: begin
                    state <= EVAL;
                end
                EVAL: begin
                    if (ben) begin
                        pc <= pc + off;
                    end
                    br_taken <= ben;
                    br_busy  <= 1'b0;
                    br_done  <= 1'b1;
                    state    <= DONE;
                end
                default: begin
                    // DONE: normal PC path is live again, br_start is dropped.
                    pc      <= pc_normal;
                    br_done <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- PC-side consumer of the registered branch-enable (BEN) bit.
- Owns the 16-bit PC register and PCMUX, and contains a small FSM that runs the BR micro-sequence when started by the ISDU.
- FSM waits for BEN to settle, then conditionally loads PC + SEXT(IR[8:0]) and returns a done/taken handshake.
- Outside a branch, PC loads follow ISDU ld_pc/pcmux_sel as usual.

Parameters:
WIDTH, 16, datapath/PC width (only 16 supported).
RESET_PC, 16'h0000, PC value after reset.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
ld_pc  input  1  ISDU PC load enable, normal path.
pcmux_sel  input  2  00 = PC+1, 01 = bus_in, 10 = PC+SEXT(ir[8:0]), 11 = hold.
bus_in  input  16  datapath bus value.
ir  input  16  current instruction register.
br_start  input  1  ISDU request to evaluate a BR; single-cycle pulse.
ben  input  1  registered BEN output from the BEN stage.
pc  output  16  current PC.
br_busy  output  1  high while FSM is in WAIT or EVAL.
br_done  output  1  one-cycle pulse; branch resolution complete.
br_taken  output  1  valid when br_done=1; 1 = PC was redirected.

Behaviour:
- Reset (sync, clk edge with reset=1):
  - pc = RESET_PC, state = IDLE, br_busy = 0, br_done = 0, br_taken = 0, captured offset = 0.
  - Reset overrides all other inputs, including mid-sequence; an in-flight branch is abandoned and no br_done is produced.
- Arithmetic: all adds are modulo 2^16 and wrap silently, e.g. 16'hFFFF+1 = 16'h0000. SEXT replicates ir[8] into bits 15:9.
- FSM states: IDLE, WAIT, EVAL, DONE.
  - IDLE: if br_start=1, capture off = SEXT(ir[8:0]) and go to WAIT. ld_pc is ignored in that cycle (br_start has priority). Otherwise stay in IDLE, normal PC path active.
  - WAIT: one cycle for the BEN register (loaded by LD_BEN alongside br_start) to become valid. br_busy = 1, ld_pc ignored. Always go to EVAL.
  - EVAL: br_busy = 1, ld_pc ignored, sample ben.
    - ben = 1: pc <= pc + off at the closing edge, taken flag = 1.
    - ben = 0: pc unchanged, taken flag = 0.
    - Always go to DONE.
  - DONE: br_done = 1, br_taken = registered taken flag, br_busy = 0. Normal ld_pc path active. br_start is ignored. Always go to IDLE.
- Outputs are registered state decodes; no combinational path from any input to any output.
- Latency: br_start sampled at edge E0 -> WAIT during cycle 1, EVAL during cycle 2, new pc visible and br_done=1 during cycle 3 -> IDLE in cycle 4. Minimum spacing between accepted br_start pulses is 4 cycles.
- Normal PC path (IDLE without br_start, or DONE):
  - ld_pc=1 loads pc per pcmux_sel; 11 = hold.
  - ld_pc=0 holds pc.
- br_taken holds its last value outside DONE and is cleared only by reset. Consumers qualify it with br_done.
- br_start while busy (WAIT/EVAL/DONE) is dropped; no queuing.
- Offset is captured at br_start, so changes to ir during the sequence have no effect. The base PC is the live pc register, which cannot change during WAIT/EVAL.

Test Plan:
- Reset, then ld_pc=1 with pcmux_sel=00 for 3 cycles -> pc=0x0000, then 0x0001, 0x0002, 0x0003. Also with pcmux_sel=01 and bus_in=0x3000 -> pc=0x3000.
- pc=0x3001, ir=0x0E05, br_start pulse, ben=1 in EVAL -> pc=0x3006 at cycle 3, br_done=1 and br_taken=1 for exactly one cycle, br_busy=1 in cycles 1-2.
- pc=0x3001, ir=0x01FE (offset -2), ben=1 -> pc=0x2FFF. Repeat with ben=0 -> pc stays 0x3001, br_taken=0, br_done pulses.
- Wrap: pc=0xFFFE, offset +5, ben=1 -> pc=0x0003.
- ld_pc=1 with pcmux_sel=01 and bus_in=0x1234, asserted during WAIT and EVAL -> pc unaffected. Extra br_start during WAIT/DONE -> ignored, exactly one br_done. ld_pc in DONE -> honoured.
- Assert reset during EVAL -> next cycle pc=RESET_PC, state IDLE, br_busy=0, and no br_done pulse follows.
